lsu_axi_master: RTL and testbench
=================================

# lsu_axi_master

Parametrised load/store unit that turns one memory request from the execute stage into a single-beat AXI4 transaction and returns one response.

- Generalises the fixed 32-bit store/load path: configurable data width, configurable transaction ID, independent AW/W handshakes.
- Adds misalignment faults, bus-error and ID-mismatch reporting, and a registered response handshake.
- Sits between the EXU and the AXI crossbar.

## Interface

Parameters:
- DATA_W, 32: AXI data width; 32 or 64.
- ADDR_W, 32: address width.
- ID_W, 4: AXI ID width.
- TXN_ID, 0: ID driven on awid/arid and expected on bid/rid.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when high together with req_valid.
- req_wr  in  1  1 = store, 0 = load.
- req_op  in  3  encoding:
  - 000 b, 001 h, 010 w, 011 d (64-bit only).
  - 100 bu, 101 hu, 110 wu (loads only).
  - 111 illegal.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores.
- rsp_err  out  2  00 ok, 01 misaligned/illegal, 10 bus error, 11 ID mismatch.
- AXI write address: awvalid/awready, awaddr[ADDR_W], awid[ID_W], awlen[8], awsize[3], awburst[2].
- AXI write data: wvalid/wready, wdata[DATA_W], wstrb[DATA_W/8], wlast.
- AXI write response: bvalid/bready, bresp[2], bid[ID_W].
- AXI read address: arvalid/arready, araddr, arid, arlen, arsize, arburst.
- AXI read data: rvalid/rready, rdata[DATA_W], rresp[2], rlast, rid[ID_W].

## Operation

- States: IDLE, WR (AW and/or W outstanding), WRESP, RADDR, RDATA, RESP.
- IDLE:
  - req_ready = 1.
  - On accept, capture addr, op, wr and lane-shifted data into registers.
  - Next state: RESP with rsp_err = 01 if misaligned, otherwise WR (store) or RADDR (load).
- Misaligned means any of:
  - addr not a multiple of 2^op[1:0];
  - op = 111;
  - op = 011 with DATA_W = 32;
  - op[2] = 1 on a store;
  - op = 110 with DATA_W = 32.
- Misaligned requests issue no bus traffic.
- Fixed AXI fields: awlen = arlen = 0, awburst = arburst = 01 (INCR), awsize = arsize = {1'b0, op[1:0]}, wlast = wvalid, ids = TXN_ID.
- Lane steering: off = addr[log2(DATA_W/8)-1:0].
  - wdata = req_wdata << 8*off.
  - wstrb = ((1 << 2^op[1:0]) - 1) << off.
- WR:
  - awvalid and wvalid rise together; each drops independently on its own handshake (flags aw_done, w_done).
  - Go to WRESP when both are done, including when both complete in the same cycle.
- WRESP: bready = 1; on bvalid, go to RESP.
- RADDR: arvalid = 1 until arready, then RDATA.
- RDATA: rready = 1; on rvalid, capture rdata, rresp and rid, then go to RESP.
- Load result: x = rdata >> 8*off, truncated to the access size, then sign-extended (op[2] = 0) or zero-extended (op[2] = 1).
- Error priority: ID mismatch (11) over bus error (10).
  - Bus error: resp[1] = 1 (SLVERR/DECERR).
  - OKAY/EXOKAY give rsp_err = 00.
  - On error, rsp_rdata = 0.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are stable until rsp_ready.
  - Then return to IDLE.
- Exactly one transaction is outstanding at a time.

## Timing

- Reset (rst low, asynchronous): state IDLE.
  - All valid/ready outputs 0 except req_ready = 1.
  - rsp_rdata = 0, rsp_err = 0.
- Reset mid-transaction drops AXI valids immediately. The interconnect is reset in the same domain.
- All outputs are registered or decoded from the state only; there is no combinational path from any input to any valid/ready output.
- Accept at cycle 0 -> awvalid/wvalid/arvalid high at cycle 1.
- With zero-wait slaves:
  - Store: handshake cycle 1, bvalid cycle 2, rsp_valid cycle 3.
  - Load: handshake cycle 1, rvalid cycle 2, rsp_valid cycle 3.
- Misaligned request: rsp_valid at cycle 1.
- The earliest back-to-back accept is the cycle after rsp_valid & rsp_ready.
- AXI valids, once high, stay high and stable until their handshake.

## Test plan

- DATA_W=32, store h 0x1234 to 0x8000_0002, all readies high:
  - Cycle 1: awaddr = 0x8000_0002, awsize = 1, wdata = 0x1234_0000, wstrb = 1100.
  - bresp OKAY -> rsp_valid at cycle 3, rsp_err = 00.
- Load b from 0x...3 with rdata = 0x80FF_FFFF:
  - op 000 -> rsp_rdata = 0xFFFF_FF80.
  - op 100 -> rsp_rdata = 0x0000_0080.
- Store w to 0x...2 -> rsp_err = 01 at cycle 1, with awvalid, wvalid and arvalid never asserted.
- AW ready 3 cycles before W ready:
  - awvalid drops at the AW handshake, wvalid holds until its own handshake.
  - bready rises only after both handshakes.
- Load with rresp = 10 -> rsp_err = 10, rsp_data 0; load with rid ≠ TXN_ID and rresp = 10 -> rsp_err = 11.
- DATA_W=64, load d from 0x...8 -> arsize = 3 and rsp_rdata = full rdata; then hold rsp_ready low 5 cycles -> outputs stable and req_ready = 0; then assert rst low mid-RDATA -> rready = 0 and req_ready = 1 without waiting for a clock edge.

Source files
------------

// File: rtl/lsu_axi_master_if.sv
// Signal bundle between the load/store unit and its surroundings: EXU request/response
// channel plus the five single-beat AXI4 channels.
interface lsu_axi_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic                req_valid;
  logic                req_ready;
  logic                req_wr;
  logic [2:0]          req_op;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [1:0]          rsp_err;

  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic [ID_W-1:0]     awid;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  logic [ID_W-1:0]     bid;

  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic [ID_W-1:0]     arid;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;

  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [ID_W-1:0]     rid;

  modport master (
    input  req_valid, req_wr, req_op, req_addr, req_wdata, rsp_ready,
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rlast, rid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, rready
  );

  modport slave (
    output req_valid, req_wr, req_op, req_addr, req_wdata, rsp_ready,
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rlast, rid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/lsu_axi_master.sv
// Load/store unit: one EXU request becomes one single-beat AXI4 transaction and one response.
// All valid/ready outputs decode the state register only.
module lsu_axi_master #(
  parameter int              DATA_W = 32,
  parameter int              ADDR_W = 32,
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] TXN_ID = '0
) (
  input logic              clk,
  input logic              rst,
  lsu_axi_master_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_done;
  logic              w_done;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [1:0]        rsp_err_q;

  logic [OFF_W-1:0]  req_off;
  logic [OFF_W-1:0]  ld_off;
  logic [2:0]        align_mask;
  logic              misaligned;
  logic [STRB_W-1:0] strb_base;
  logic              aw_hs;
  logic              w_hs;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] rd_ext;
  logic              rd_sign;
  logic [1:0]        b_err;
  logic [1:0]        r_err;
  logic              unused_ok;

  assign req_off = bus.req_addr[OFF_W-1:0];
  assign ld_off  = addr_q[OFF_W-1:0];

  always_comb begin
    align_mask = 3'b000;
    case (bus.req_op[1:0])
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  // Any of these faults answers immediately without touching the bus.
  assign misaligned = (|(bus.req_addr[2:0] & align_mask))
                    || (bus.req_op == 3'b111)
                    || (bus.req_op == 3'b011 && DATA_W == 32)
                    || (bus.req_op[2] && bus.req_wr)
                    || (bus.req_op == 3'b110 && DATA_W == 32);

  always_comb begin
    strb_base = '0;
    for (int i = 0; i < STRB_W; i++) strb_base[i] = (i < (1 << bus.req_op[1:0]));
  end

  assign rd_shift = bus.rdata >> {ld_off, 3'b000};

  // Truncate the shifted read lane to the access size, then sign- or zero-extend.
  always_comb begin
    rd_sign = 1'b0;
    rd_ext  = '0;
    case (op_q[1:0])
      2'd0:    rd_sign = rd_shift[7];
      2'd1:    rd_sign = rd_shift[15];
      2'd2:    rd_sign = rd_shift[31];
      default: rd_sign = rd_shift[DATA_W-1];
    endcase
    rd_sign = rd_sign & ~op_q[2];
    for (int i = 0; i < DATA_W; i++) rd_ext[i] = (i < (8 << op_q[1:0])) ? rd_shift[i] : rd_sign;
  end

  assign b_err = (bus.bid != TXN_ID) ? 2'b11 : (bus.bresp[1] ? 2'b10 : 2'b00);
  assign r_err = (bus.rid != TXN_ID) ? 2'b11 : (bus.rresp[1] ? 2'b10 : 2'b00);

  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid & bus.wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      op_q        <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            op_q    <= bus.req_op;
            wdata_q <= bus.req_wdata << {req_off, 3'b000};
            wstrb_q <= strb_base << req_off;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (misaligned) begin
              rsp_err_q   <= 2'b01;
              rsp_rdata_q <= '0;
              state       <= S_RESP;
            end else begin
              state <= bus.req_wr ? S_WR : S_RADDR;
            end
          end
        end
        // AW and W complete independently, possibly in the same cycle.
        S_WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs) w_done <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= S_WRESP;
        end
        S_WRESP: begin
          if (bus.bvalid) begin
            rsp_err_q   <= b_err;
            rsp_rdata_q <= '0;
            state       <= S_RESP;
          end
        end
        S_RADDR: begin
          if (bus.arready) state <= S_RDATA;
        end
        S_RDATA: begin
          if (bus.rvalid) begin
            rsp_err_q   <= r_err;
            rsp_rdata_q <= (r_err == 2'b00) ? rd_ext : '0;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign bus.awvalid = (state == S_WR) && !aw_done;
  assign bus.awaddr  = addr_q;
  assign bus.awid    = TXN_ID;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = {1'b0, op_q[1:0]};
  assign bus.awburst = 2'b01;

  assign bus.wvalid = (state == S_WR) && !w_done;
  assign bus.wdata  = wdata_q;
  assign bus.wstrb  = wstrb_q;
  assign bus.wlast  = bus.wvalid;

  assign bus.bready = (state == S_WRESP);

  assign bus.arvalid = (state == S_RADDR);
  assign bus.araddr  = addr_q;
  assign bus.arid    = TXN_ID;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, op_q[1:0]};
  assign bus.arburst = 2'b01;

  assign bus.rready = (state == S_RDATA);

  assign unused_ok = ^{bus.rlast, bus.rresp[0], bus.bresp[0]};
endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: a 32-bit and a 64-bit instance share one driver, selected by 'sel',
// and are checked against an arithmetic reference model with timed slave responses.
module tb_lsu_axi_master;
  localparam logic [3:0] TXN_ID = 4'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  bit   sel;
  int   checks = 0;
  int   errors = 0;

  logic        req_valid, req_wr, rsp_ready, awready, wready, bvalid, arready, rvalid, rlast;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, rdata;
  logic [1:0]  bresp, rresp;
  logic [3:0]  bid, rid;

  logic        req_ready, rsp_valid, awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [63:0] rsp_rdata, wdata;
  logic [1:0]  rsp_err, awburst, arburst;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awid, arid;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [6:0]  hs_vec;

  lsu_axi_master_if #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) b32 ();
  lsu_axi_master_if #(.DATA_W(64), .ADDR_W(32), .ID_W(4)) b64 ();

  lsu_axi_master #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .TXN_ID(TXN_ID)) dut32 (
    .clk(clk), .rst(rst), .bus(b32));
  lsu_axi_master #(.DATA_W(64), .ADDR_W(32), .ID_W(4), .TXN_ID(TXN_ID)) dut64 (
    .clk(clk), .rst(rst), .bus(b64));

  assign b32.req_valid = req_valid & ~sel;
  assign b32.req_wr    = req_wr;
  assign b32.req_op    = req_op;
  assign b32.req_addr  = req_addr;
  assign b32.req_wdata = req_wdata[31:0];
  assign b32.rsp_ready = rsp_ready & ~sel;
  assign b32.awready   = awready;
  assign b32.wready    = wready;
  assign b32.bvalid    = bvalid & ~sel;
  assign b32.bresp     = bresp;
  assign b32.bid       = bid;
  assign b32.arready   = arready;
  assign b32.rvalid    = rvalid & ~sel;
  assign b32.rdata     = rdata[31:0];
  assign b32.rresp     = rresp;
  assign b32.rlast     = rlast;
  assign b32.rid       = rid;

  assign b64.req_valid = req_valid & sel;
  assign b64.req_wr    = req_wr;
  assign b64.req_op    = req_op;
  assign b64.req_addr  = req_addr;
  assign b64.req_wdata = req_wdata;
  assign b64.rsp_ready = rsp_ready & sel;
  assign b64.awready   = awready;
  assign b64.wready    = wready;
  assign b64.bvalid    = bvalid & sel;
  assign b64.bresp     = bresp;
  assign b64.bid       = bid;
  assign b64.arready   = arready;
  assign b64.rvalid    = rvalid & sel;
  assign b64.rdata     = rdata;
  assign b64.rresp     = rresp;
  assign b64.rlast     = rlast;
  assign b64.rid       = rid;

  assign req_ready = sel ? b64.req_ready : b32.req_ready;
  assign rsp_valid = sel ? b64.rsp_valid : b32.rsp_valid;
  assign rsp_rdata = sel ? b64.rsp_rdata : {32'd0, b32.rsp_rdata};
  assign rsp_err   = sel ? b64.rsp_err   : b32.rsp_err;
  assign awvalid   = sel ? b64.awvalid   : b32.awvalid;
  assign awaddr    = sel ? b64.awaddr    : b32.awaddr;
  assign awid      = sel ? b64.awid      : b32.awid;
  assign awlen     = sel ? b64.awlen     : b32.awlen;
  assign awsize    = sel ? b64.awsize    : b32.awsize;
  assign awburst   = sel ? b64.awburst   : b32.awburst;
  assign wvalid    = sel ? b64.wvalid    : b32.wvalid;
  assign wdata     = sel ? b64.wdata     : {32'd0, b32.wdata};
  assign wstrb     = sel ? b64.wstrb     : {4'd0, b32.wstrb};
  assign wlast     = sel ? b64.wlast     : b32.wlast;
  assign bready    = sel ? b64.bready    : b32.bready;
  assign arvalid   = sel ? b64.arvalid   : b32.arvalid;
  assign araddr    = sel ? b64.araddr    : b32.araddr;
  assign arid      = sel ? b64.arid      : b32.arid;
  assign arlen     = sel ? b64.arlen     : b32.arlen;
  assign arsize    = sel ? b64.arsize    : b32.arsize;
  assign arburst   = sel ? b64.arburst   : b32.arburst;
  assign rready    = sel ? b64.rready    : b32.rready;

  assign hs_vec = {req_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid};

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference results computed from byte-lane arithmetic for the selected data width.
  task automatic model(input bit w64, input bit wr, input logic [2:0] op, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [1:0] resp, input logic [3:0] id,
                       input logic [63:0] rd, output bit misal, output logic [63:0] eWdata,
                       output logic [7:0] eStrb, output logic [1:0] eErr, output logic [63:0] eRdata);
    int bytes, size, off, nbits;
    logic [63:0] wmask, vmask, x, val;
    bytes = w64 ? 8 : 4;
    size  = 1 << op[1:0];
    off   = int'(addr[2:0]) % bytes;
    misal = (int'(addr[2:0]) % size != 0) || op == 3'b111 || (op == 3'b011 && !w64)
            || (op[2] && wr) || (op == 3'b110 && !w64);
    wmask  = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    eWdata = (wd << (8 * off)) & wmask;
    eStrb  = 8'((((1 << size) - 1) << off) & (w64 ? 255 : 15));
    x      = (rd & wmask) >> (8 * off);
    nbits  = 8 * size;
    vmask  = (nbits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
    val    = x & vmask;
    if (!op[2] && x[nbits-1]) val = val | ~vmask;
    val = val & wmask;
    if (misal) eErr = 2'b01;
    else if (id != TXN_ID) eErr = 2'b11;
    else if (resp[1]) eErr = 2'b10;
    else eErr = 2'b00;
    eRdata = (eErr != 2'b00 || wr) ? 64'd0 : val;
  endtask

  // One complete request: dly0 = AW/AR ready delay, dly1 = W ready delay, dly2 = B/R delay.
  task automatic applyStimulus(input bit wr, input logic [2:0] op, input logic [31:0] addr,
                               input logic [63:0] wd, input int dly0, input int dly1, input int dly2,
                               input logic [1:0] resp, input logic [3:0] id, input logic [63:0] rd,
                               input int hold);
    bit misal;
    logic [63:0] eWdata, eRdata;
    logic [7:0] eStrb;
    logic [1:0] eErr;
    logic [6:0] eVec;
    int hs0, hs1, both, hsEnd, rspC;
    model(sel, wr, op, addr, wd, resp, id, rd, misal, eWdata, eStrb, eErr, eRdata);
    hs0 = 1 + dly0;
    hs1 = 1 + dly1;
    both = (hs0 > hs1) ? hs0 : hs1;
    if (misal) begin
      hsEnd = 0;
      rspC  = 1;
    end else begin
      hsEnd = (wr ? both : hs0) + 1 + dly2;
      rspC  = hsEnd + 1;
    end

    @(negedge clk);
    checkOutput("idle", hs_vec, 7'b1000000);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wr = wr; req_op = op; req_addr = addr; req_wdata = wd;
    bresp = resp; rresp = resp; bid = id; rid = id; rdata = rd; rlast = 1'b1;
    for (int k = 1; k <= rspC; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = {$urandom, $urandom};
      eVec = 7'b0;
      eVec[0] = (k == rspC);
      if (!misal && wr) begin
        eVec[5] = (k <= hs0);
        eVec[4] = (k <= hs1);
        eVec[3] = (k > both) && (k <= hsEnd);
      end else if (!misal) begin
        eVec[2] = (k <= hs0);
        eVec[1] = (k > hs0) && (k <= hsEnd);
      end
      checkOutput("handshake", hs_vec, eVec);
      if (eVec[5]) checkOutput("aw", {awaddr, awid, awlen, awsize, awburst},
                               {addr, TXN_ID, 8'd0, {1'b0, op[1:0]}, 2'b01});
      if (eVec[4]) checkOutput("w", {wdata, wstrb, wlast}, {eWdata, eStrb, 1'b1});
      if (eVec[2]) checkOutput("ar", {araddr, arid, arlen, arsize, arburst},
                               {addr, TXN_ID, 8'd0, {1'b0, op[1:0]}, 2'b01});
      awready = (k >= hs0);
      wready  = (k >= hs1);
      arready = (k >= hs0);
      bvalid  = !misal && wr && (k == hsEnd);
      rvalid  = !misal && !wr && (k == hsEnd);
      if (k == rspC) begin
        checkOutput("rsp", {rsp_err, rsp_rdata}, {eErr, eRdata});
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        rsp_ready = (hold == 0);
      end
    end
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      checkOutput("hold", hs_vec, 7'b0000001);
      checkOutput("hold_rsp", {rsp_err, rsp_rdata}, {eErr, eRdata});
      rsp_ready = (h == hold);
    end
  endtask

  task automatic randomTxns(input int n);
    bit wr;
    logic [2:0] op;
    logic [31:0] addr;
    logic [3:0] id;
    for (int i = 0; i < n; i++) begin
      wr   = 1'($urandom_range(1));
      op   = 3'($urandom_range(7));
      addr = $urandom;
      if ($urandom_range(3) != 0) addr = addr & ~((32'd1 << op[1:0]) - 32'd1);
      id   = ($urandom_range(4) == 0) ? 4'($urandom_range(15)) : TXN_ID;
      applyStimulus(wr, op, addr, {$urandom, $urandom}, $urandom_range(3), $urandom_range(3),
                    $urandom_range(3), 2'($urandom_range(3)), id, {$urandom, $urandom},
                    $urandom_range(2));
    end
  endtask

  initial begin
    sel = 1'b0; rst = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_op = 3'b0; req_addr = 32'd0; req_wdata = 64'd0;
    rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; rdata = 64'd0; bresp = 2'b0; rresp = 2'b0; bid = 4'd0; rid = 4'd0;
    #1;
    checkOutput("reset_hs", hs_vec, 7'b1000000);
    checkOutput("reset_rsp", {rsp_err, rsp_rdata}, 66'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    applyStimulus(1'b1, 3'b001, 32'h8000_0002, 64'h1234, 0, 0, 0, 2'b00, TXN_ID, 64'd0, 0);
    applyStimulus(1'b0, 3'b000, 32'h8000_0003, 64'd0, 0, 0, 0, 2'b00, TXN_ID, 64'h80FF_FFFF, 0);
    applyStimulus(1'b0, 3'b100, 32'h8000_0003, 64'd0, 0, 0, 0, 2'b00, TXN_ID, 64'h80FF_FFFF, 0);
    applyStimulus(1'b1, 3'b010, 32'h8000_0002, 64'hDEAD_BEEF, 0, 0, 0, 2'b00, TXN_ID, 64'd0, 1);
    applyStimulus(1'b1, 3'b010, 32'h8000_0004, 64'hCAFE_F00D, 0, 3, 1, 2'b00, TXN_ID, 64'd0, 0);
    applyStimulus(1'b1, 3'b000, 32'h8000_0005, 64'h00A5, 2, 0, 0, 2'b01, TXN_ID, 64'd0, 0);
    applyStimulus(1'b0, 3'b010, 32'h8000_0008, 64'd0, 1, 0, 2, 2'b10, TXN_ID, 64'h1111_2222, 0);
    applyStimulus(1'b0, 3'b010, 32'h8000_0008, 64'd0, 0, 0, 0, 2'b10, 4'd3, 64'h1111_2222, 0);
    randomTxns(150);

    @(negedge clk);
    sel = 1'b1;
    randomTxns(100);
    applyStimulus(1'b0, 3'b011, 32'h8000_0008, 64'd0, 0, 0, 0, 2'b00, TXN_ID,
                  64'h8123_4567_89AB_CDEF, 5);

    @(negedge clk);
    checkOutput("idle", hs_vec, 7'b1000000);
    req_valid = 1'b1; req_wr = 1'b0; req_op = 3'b011; req_addr = 32'h8000_0010; arready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rst_ar", hs_vec, 7'b0000100);
    @(negedge clk);
    checkOutput("rst_rdata", hs_vec, 7'b0000010);
    arready = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_hs", hs_vec, 7'b1000000);
    checkOutput("async_rst_rsp", {rsp_err, rsp_rdata}, 66'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst", hs_vec, 7'b1000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
